mix_columns_engine: RTL and testbench
=====================================

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, meaning 32-bit columns transformed per clock; legal values 1, 2, 4.
REQ-002 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: in_valid  input  1  input block offered.
REQ-005 SHALL have ports: in_ready  output  1  engine can accept a block.
REQ-006 SHALL have ports: in_data  input  128  AES state; column c = bits [127-32c -: 32]; row 0 = MSB byte of each column.
REQ-007 SHALL have ports: in_inv  input  1  0 = MixColumns, 1 = InvMixColumns.
REQ-008 SHALL have ports: out_valid  output  1  result held.
REQ-009 SHALL have ports: out_ready  input  1  downstream accepts result.
REQ-010 SHALL have ports: out_data  output  128  transformed state, same layout as in_data.

Function
REQ-011 SHALL implement FSM IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-012 SHALL accept a block on a rising edge with IDLE and in_valid = 1, registering in_data and in_inv, clearing column counter, entering BUSY.
REQ-013 SHALL in BUSY transform COLS_PER_CYCLE columns per cycle, column 0 first, writing results in place; enter DONE after the 4/COLS_PER_CYCLE-th BUSY cycle.
REQ-014 SHALL give out_valid exactly 4/COLS_PER_CYCLE cycles after the accept edge (4, 2, 1 cycles).
REQ-015 SHALL hold out_data and out_valid stable in DONE until out_ready = 1, then return to IDLE on that edge.
REQ-016 SHALL NOT accept a new block in the DONE-to-IDLE edge; next accept earliest one cycle later (in_ready registered-state based, no combinational path from out_ready).
REQ-017 SHALL use forward matrix rows {02 03 01 01} rotated; inverse rows {0E 0B 0D 09} rotated; GF(2^8) with polynomial 0x11B; all products 8-bit.
REQ-018 SHALL ignore in_inv, in_data outside accept edges; in_valid while BUSY/DONE has no effect.

Reset
REQ-019 SHALL on rst = 1 immediately force IDLE, in_ready = 1, out_valid = 0, out_data = 0, counter = 0, stored mode = 0.
REQ-020 SHALL on reset during BUSY or DONE discard the block; no out_valid follows.

Configuration
REQ-021 SHALL use macro MIX_COLUMNS_INV_EN: defined -> inverse datapath compiled, in_inv honoured; undefined -> inverse datapath absent, in_inv ignored, forward only, port list unchanged.

Structure
REQ-022 SHALL place xtime/GF-multiply functions, polynomial constant 0x11B, and FSM state enum in shared package aes_pkg.
REQ-023 SHALL instantiate COLS_PER_CYCLE copies of sub-module mix_column_word (combinational, 32-bit column in, inv select, 32-bit out).

Verification
REQ-024 SHALL check forward, COLS_PER_CYCLE = 1: columns db135345, f20a225c, 01010101, c6c6c6c6 -> 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6; out_valid 4 cycles after accept.
REQ-025 SHALL check inverse (macro defined): 8e4da1bc 9fdc589d 01010101 c6c6c6c6 -> db135345 f20a225c 01010101 c6c6c6c6; with macro undefined same stimulus gives forward result.
REQ-026 SHALL check COLS_PER_CYCLE = 2 and 4 with columns d4d4d4d5, 2d26314c -> d5d5d7d6, 4d7ebdf8; latency 2 and 1 cycles respectively.
REQ-027 SHALL check backpressure: out_ready held 0 for 10 cycles -> out_data stable, in_ready = 0, in_valid ignored; release -> IDLE next edge.
REQ-028 SHALL check reset asserted mid-BUSY (counter = 2): outputs reset asynchronously, no out_valid, next block processed correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared GF(2^8) arithmetic and engine state encoding for the AES column mixer.
package aes_pkg;

  // AES field polynomial x^8 + x^4 + x^3 + x + 1
  localparam logic [8:0] AES_POLY = 9'h11B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_t;

  // Multiply by x, folding the overflow bit back in with the field polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY[7:0] : 8'h00);
  endfunction

  // Multiply by a small constant (the matrix only needs 1..0x0E) as a sum of x^k multiples.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? a  : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^
           (k[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// mix_column_word: combinational MixColumns / InvMixColumns of one 32-bit column.
// Byte 0 (row 0) is the MSB byte. The inverse path exists only when
// MIX_COLUMNS_INV_EN is defined; otherwise inv is ignored.
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] result
);

  logic [7:0] a   [4];
  logic [7:0] fwd [4];

  assign a[0] = col[31:24];
  assign a[1] = col[23:16];
  assign a[2] = col[15:8];
  assign a[3] = col[7:0];

  // Each output row uses the base row {02 03 01 01} rotated right by the row number.
  for (genvar r = 0; r < 4; r++) begin : g_fwd
    assign fwd[r] = gf_mul(a[r], 4'h2) ^ gf_mul(a[(r+1)%4], 4'h3) ^
                    a[(r+2)%4] ^ a[(r+3)%4];
  end

`ifdef MIX_COLUMNS_INV_EN
  logic [7:0] bwd [4];

  // Inverse rows follow the same rotation with base {0E 0B 0D 09}.
  for (genvar r = 0; r < 4; r++) begin : g_inv
    assign bwd[r] = gf_mul(a[r], 4'hE) ^ gf_mul(a[(r+1)%4], 4'hB) ^
                    gf_mul(a[(r+2)%4], 4'hD) ^ gf_mul(a[(r+3)%4], 4'h9);
  end

  assign result = inv ? {bwd[0], bwd[1], bwd[2], bwd[3]}
                      : {fwd[0], fwd[1], fwd[2], fwd[3]};
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign result = {fwd[0], fwd[1], fwd[2], fwd[3]};
`endif

endmodule

// File: rtl/mix_columns_engine.sv
// mix_columns_engine: iterative AES MixColumns over a 128-bit state,
// COLS_PER_CYCLE columns per clock, column 0 first, results written in place.
// Optional macro MIX_COLUMNS_INV_EN compiles in the inverse transform (in_inv).
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int         STEPS     = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

  mc_state_t   state;
  logic [1:0]  step;
  logic        inv_q;
  logic        mode_in;
  logic [31:0] cols_q  [4];
  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

`ifdef MIX_COLUMNS_INV_EN
  assign mode_in = in_inv;
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign mode_in       = 1'b0;
`endif

  // Lane i of step s works on column s*COLS_PER_CYCLE + i.
  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
    assign col_idx[i] = 2'(int'(step) * COLS_PER_CYCLE + i);
    assign col_in[i]  = cols_q[col_idx[i]];

    mix_column_word u_word (
      .col    (col_in[i]),
      .inv    (inv_q),
      .result (col_out[i])
    );
  end

  // Handshake FSM: accept in IDLE, transform in BUSY, hold the result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      step  <= '0;
      inv_q <= 1'b0;
      for (int k = 0; k < 4; k++) cols_q[k] <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < 4; k++) cols_q[k] <= in_data[127-32*k -: 32];
            inv_q <= mode_in;
            step  <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          for (int i = 0; i < COLS_PER_CYCLE; i++) cols_q[col_idx[i]] <= col_out[i];
          if (step == LAST_STEP) begin
            step  <= '0;
            state <= ST_DONE;
          end else begin
            step <= step + 2'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_data  = {cols_q[0], cols_q[1], cols_q[2], cols_q[3]};

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine: three engines (1, 2 and 4 columns per cycle) checked
// against a matrix-multiply reference model over GF(2^8).
module tb_mix_columns_engine;

`ifdef MIX_COLUMNS_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic [2:0]        in_valid_v;
  logic [2:0]        in_ready_v;
  logic [2:0]        in_inv_v;
  logic [2:0]        out_valid_v;
  logic [2:0]        out_ready_v;
  logic [2:0][127:0] in_data_v;
  logic [2:0][127:0] out_data_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mix_columns_engine #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data_v[0]), .in_inv(in_inv_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_data(out_data_v[0])
  );

  mix_columns_engine #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data_v[1]), .in_inv(in_inv_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_data(out_data_v[1])
  );

  mix_columns_engine #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data_v[2]), .in_inv(in_inv_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .out_data(out_data_v[2])
  );

  // Carry-less polynomial product followed by reduction modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  // State times circulant matrix, one column at a time.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) begin
      base[0] = 8'h0E; base[1] = 8'h0B; base[2] = 8'h0D; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(base[(k - row + 4) % 4], s[127 - 32*c - 8*k -: 8]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    return r;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 2 : 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one block, keep poking junk at the inputs while it runs, check
  // latency and result, optionally stall the output, then release it.
  task automatic applyStimulus(input int d, input logic [127:0] data, input logic inv,
                               input logic [127:0] expected, input int hold);
    int lat;
    checkOutput("in_ready_idle", 128'(in_ready_v[d]), 128'd1);
    in_valid_v[d] = 1'b1;
    in_data_v[d]  = data;
    in_inv_v[d]   = inv;
    @(posedge clk); #1;
    in_data_v[d] = {$urandom, $urandom, $urandom, $urandom};
    in_inv_v[d]  = ~inv;
    checkOutput("in_ready_busy", 128'(in_ready_v[d]), 128'd0);
    lat = 0;
    while (!out_valid_v[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      in_data_v[d] = {$urandom, $urandom, $urandom, $urandom};
    end
    checkOutput("latency", 128'(lat), 128'(lat_of(d)));
    checkOutput("result", out_data_v[d], expected);
    for (int h = 0; h < hold; h++) begin
      in_data_v[d] = {$urandom, $urandom, $urandom, $urandom};
      in_inv_v[d]  = $urandom_range(0, 1) == 1;
      @(posedge clk); #1;
      checkOutput("hold_data", out_data_v[d], expected);
      checkOutput("hold_flags", 128'({in_ready_v[d], out_valid_v[d]}), 128'(2'b01));
    end
    out_ready_v[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[d] = 1'b0;
    checkOutput("release", 128'({in_ready_v[d], out_valid_v[d]}), 128'(2'b10));
    in_valid_v[d] = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_again", 128'({in_ready_v[d], out_valid_v[d]}), 128'(2'b10));
  endtask

  initial begin
    logic [127:0] v_fwd_in, v_fwd_out, v_inv_exp, v_wide_in, v_wide_out, data;
    logic         inv;
    logic         seen_valid;

    v_fwd_in   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    v_fwd_out  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    v_wide_in  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    v_wide_out = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
    v_inv_exp  = INV_EN ? v_fwd_in : ref_mix(v_fwd_out, 1'b0);

    in_valid_v  = '0;
    in_inv_v    = '0;
    out_ready_v = '0;
    in_data_v   = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      checkOutput("reset_in_ready", 128'(in_ready_v[d]), 128'd1);
      checkOutput("reset_out_valid", 128'(out_valid_v[d]), 128'd0);
      checkOutput("reset_out_data", out_data_v[d], 128'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    applyStimulus(0, v_fwd_in, 1'b0, v_fwd_out, 10);
    applyStimulus(0, v_fwd_out, 1'b1, v_inv_exp, 0);
    applyStimulus(1, v_wide_in, 1'b0, v_wide_out, 3);
    applyStimulus(2, v_wide_in, 1'b0, v_wide_out, 3);
    applyStimulus(1, v_wide_out, 1'b1, INV_EN ? v_wide_in : ref_mix(v_wide_out, 1'b0), 0);
    applyStimulus(2, v_wide_out, 1'b1, INV_EN ? v_wide_in : ref_mix(v_wide_out, 1'b0), 0);

    $display("[TB] random blocks");
    for (int d = 0; d < 3; d++)
      for (int n = 0; n < 6; n++) begin
        data = {$urandom, $urandom, $urandom, $urandom};
        inv  = $urandom_range(0, 1) == 1;
        applyStimulus(d, data, inv, ref_mix(data, inv & INV_EN), $urandom_range(0, 2));
      end

    $display("[TB] reset during busy");
    data = {$urandom, $urandom, $urandom, $urandom};
    in_valid_v[0] = 1'b1;
    in_data_v[0]  = data;
    in_inv_v[0]   = 1'b0;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_in_ready", 128'(in_ready_v[0]), 128'd1);
    checkOutput("midreset_out_valid", 128'(out_valid_v[0]), 128'd0);
    checkOutput("midreset_out_data", out_data_v[0], 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      seen_valid |= out_valid_v[0];
    end
    checkOutput("midreset_no_valid", 128'(seen_valid), 128'd0);
    data = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(0, data, 1'b0, ref_mix(data, 1'b0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
